// File: rtl/pb_itf_multi_pkg.sv
// -----------------------------------------------------------------------------
// pb_itf_multi_pkg
//   Shared definitions for the multi-channel push-button interface:
//   - default timing counts for the board clock (debounce, long press, repeat)
//   - per-channel FSM state encodings
//   - small constant helpers used to size the channel counters
//   No ports; imported by pb_chan and pb_itf_multi.
// -----------------------------------------------------------------------------
package pb_itf_multi_pkg;

    // Default timing for the board clock, in sysclk cycles.
    localparam int DEF_DEB_CYC = 20;
    localparam int DEF_LP_CYC  = 1000;
    localparam int DEF_RPT_CYC = 250;

    // Per-channel FSM state encodings.
    localparam logic [1:0] ST_LOCK  = 2'd0;  // ignore key until first seen released
    localparam logic [1:0] ST_IDLE  = 2'd1;  // released, waiting for a press
    localparam logic [1:0] ST_PRESS = 2'd2;  // pressed, counting towards long press
    localparam logic [1:0] ST_HOLD  = 2'd3;  // long press done, auto-repeat phase

    // Bits needed to hold the value max_val (at least 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pb_chan.sv
// -----------------------------------------------------------------------------
// pb_chan
//   One push-button channel: 2-FF synchroniser, debouncer and press
//   classification FSM. The raw input is already normalised (1 = pressed).
//
//   Ports
//     sysclk        in  1  system clock, rising edge
//     rst           in  1  synchronous active-high reset
//     key_pressed   in  1  raw asynchronous key, 1 = pressed
//     key_level     out 1  debounced level, 1 = pressed
//     short_press   out 1  1-cycle pulse, released before LP_CYC hold cycles
//     long_press    out 1  1-cycle pulse, hold reached LP_CYC cycles
//     repeat_press  out 1  1-cycle pulse every RPT_CYC cycles after long press
// -----------------------------------------------------------------------------
module pb_chan
    import pb_itf_multi_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC,
    parameter int LP_CYC  = DEF_LP_CYC,
    parameter int RPT_EN  = 1,
    parameter int RPT_CYC = DEF_RPT_CYC
) (
    input  logic sysclk,
    input  logic rst,
    input  logic key_pressed,
    output logic key_level,
    output logic short_press,
    output logic long_press,
    output logic repeat_press
);

    localparam int DEB_W = cnt_width(DEB_CYC);
    localparam int HC_W  = cnt_width(max2(LP_CYC, RPT_CYC));

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [HC_W-1:0]  LP_LAST  = HC_W'(LP_CYC - 1);
    localparam logic [HC_W-1:0]  RPT_LAST = HC_W'(RPT_CYC - 1);
    localparam logic [HC_W-1:0]  HC_MAX   = '1;

    logic             sync_p0;
    logic             sync_p1;
    logic             deb_q;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_flip;
    logic             deb_next;
    logic [1:0]       state;
    logic [HC_W-1:0]  hc;

    // ---- stage p0/p1: two-flop synchroniser ----
    // Deliberately not reset: after reset the LOCK state needs the key's real
    // level straight away so that a key held through reset stays locked out.
    always_ff @(posedge sysclk) begin
        sync_p0 <= key_pressed;
        sync_p1 <= sync_p0;
    end

    // ---- debounce: accept a level only after DEB_CYC stable cycles ----
    // deb_next is the level being accepted on this edge; the FSM looks at it
    // so that events line up with the cycle key_level changes.
    assign deb_flip = (sync_p1 != deb_q) && (deb_cnt == DEB_LAST);
    assign deb_next = deb_q ^ deb_flip;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            deb_q   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            deb_q <= deb_next;
            if ((sync_p1 == deb_q) || deb_flip) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_LAST) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign key_level = deb_q;

    // ---- classification FSM ----
    // PRESS/HOLD release checks come first so a release always wins over a
    // long press or repeat that falls due on the same edge.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state        <= ST_LOCK;
            hc           <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_press <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_press <= 1'b0;
            case (state)
                ST_LOCK: begin
                    // Leave only once the key is really released, not merely
                    // because the debouncer came out of reset at "released".
                    if (!deb_next && !sync_p1) begin
                        state <= ST_IDLE;
                    end
                    hc <= '0;
                end
                ST_IDLE: begin
                    if (deb_next) begin
                        state <= ST_PRESS;
                    end
                    hc <= '0;
                end
                ST_PRESS: begin
                    if (!deb_next) begin
                        short_press <= 1'b1;
                        state       <= ST_IDLE;
                        hc          <= '0;
                    end else if (hc == LP_LAST) begin
                        long_press <= 1'b1;
                        state      <= ST_HOLD;
                        hc         <= '0;
                    end else if (hc != HC_MAX) begin
                        hc <= hc + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!deb_next) begin
                        state <= ST_IDLE;
                        hc    <= '0;
                    end else if (RPT_EN != 0) begin
                        if (hc == RPT_LAST) begin
                            repeat_press <= 1'b1;
                            hc           <= '0;
                        end else if (hc != HC_MAX) begin
                            hc <= hc + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_LOCK;
                    hc    <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pb_itf_multi.sv
// -----------------------------------------------------------------------------
// pb_itf_multi
//   Multi-channel push-button interface. Normalises key polarity to
//   pressed = 1 and fans the bus out to N_KEYS independent pb_chan instances.
//
//   Ports
//     sysclk        in  1       system clock, rising edge
//     rst           in  1       synchronous active-high reset
//     key           in  N_KEYS  raw asynchronous buttons, polarity per ACTIVE_LOW
//     key_level     out N_KEYS  debounced level, 1 = pressed
//     short_press   out N_KEYS  1-cycle pulse on release before long press
//     long_press    out N_KEYS  1-cycle pulse when hold reaches LP_CYC
//     repeat_press  out N_KEYS  1-cycle pulse every RPT_CYC while held after long
// -----------------------------------------------------------------------------
module pb_itf_multi
    import pb_itf_multi_pkg::*;
#(
    parameter int N_KEYS     = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int DEB_CYC    = DEF_DEB_CYC,
    parameter int LP_CYC     = DEF_LP_CYC,
    parameter int RPT_EN     = 1,
    parameter int RPT_CYC    = DEF_RPT_CYC
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] short_press,
    output logic [N_KEYS-1:0] long_press,
    output logic [N_KEYS-1:0] repeat_press
);

    logic [N_KEYS-1:0] key_pressed;

    // Inverting ahead of the synchroniser is equivalent to inverting after it.
    assign key_pressed = (ACTIVE_LOW != 0) ? ~key : key;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        pb_chan #(
            .DEB_CYC (DEB_CYC),
            .LP_CYC  (LP_CYC),
            .RPT_EN  (RPT_EN),
            .RPT_CYC (RPT_CYC)
        ) u_chan (
            .sysclk       (sysclk),
            .rst          (rst),
            .key_pressed  (key_pressed[i]),
            .key_level    (key_level[i]),
            .short_press  (short_press[i]),
            .long_press   (long_press[i]),
            .repeat_press (repeat_press[i])
        );
    end

endmodule

// File: tb/tb_pb_itf_multi.sv
module tb_pb_itf_multi;

    logic       sysclk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic [3:0] key_level;
    logic [3:0] short_press;
    logic [3:0] long_press;
    logic [3:0] repeat_press;

    pb_itf_multi #(
        .N_KEYS     (4),
        .ACTIVE_LOW (1),
        .DEB_CYC    (4),
        .LP_CYC     (20),
        .RPT_EN     (1),
        .RPT_CYC    (8)
    ) dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .key          (key),
        .key_level    (key_level),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_press (repeat_press)
    );

    always #5 sysclk = ~sysclk;

    // Number of rising edges so far; read on the falling edge.
    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] sp;
        logic [3:0] lp;
        logic [3:0] rp;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    // Scoreboard monitor: every pulse cycle must match the head of the queue,
    // and any expected entry whose cycle has passed unseen is a miss.
    always @(negedge sysclk) begin
        if (mon_en) begin
            if ((short_press | long_press | repeat_press) != 4'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d got sp=%b lp=%b rp=%b, expected no pulse",
                             cyc, short_press, long_press, repeat_press);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.sp !== short_press || mon_e.lp !== long_press ||
                        mon_e.rp !== repeat_press || mon_e.at != cyc) begin
                        errors++;
                        $display("FAIL pulse got sp=%b lp=%b rp=%b at cyc %0d, expected sp=%b lp=%b rp=%b at cyc %0d",
                                 short_press, long_press, repeat_press, cyc,
                                 mon_e.sp, mon_e.lp, mon_e.rp, mon_e.at);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].at < cyc) begin
                checks++;
                errors++;
                mon_e = exp_q.pop_front();
                $display("FAIL missed_pulse got none by cyc %0d, expected sp=%b lp=%b rp=%b at cyc %0d",
                         cyc, mon_e.sp, mon_e.lp, mon_e.rp, mon_e.at);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic push(input logic [3:0] sp, input logic [3:0] lp,
                        input logic [3:0] rp, input int at);
        exp_t e;
        e.sp = sp;
        e.lp = lp;
        e.rp = rp;
        e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    int         c0;
    logic [3:0] lv_or;

    initial begin
        key = 4'hF;
        rst = 1'b1;

        // Reset state
        tick(4);
        check("rst_level", 32'(key_level), 0);
        check("rst_short", 32'(short_press), 0);
        check("rst_long_rpt", 32'(long_press | repeat_press), 0);
        rst = 1'b0;
        tick(3);
        check("post_rst_level", 32'(key_level), 0);
        mon_en = 1'b1;
        tick(5);

        // Glitch: 3 cycles low must not change the level or produce pulses
        key[0] = 1'b0;
        tick(3);
        key[0] = 1'b1;
        lv_or = 4'b0;
        repeat (12) begin
            tick(1);
            lv_or = lv_or | key_level;
        end
        check("glitch_level", 32'(lv_or), 0);

        // Short press on key[1], 10 cycles: level at +6, short at +16
        c0 = cyc;
        push(4'b0010, 4'b0000, 4'b0000, c0 + 16);
        key[1] = 1'b0;
        tick(5);
        check("short_level_pre", 32'(key_level[1]), 0);
        tick(1);
        check("short_level_rise", 32'(key_level[1]), 1);
        tick(4);
        key[1] = 1'b1;
        tick(5);
        check("short_level_held", 32'(key_level[1]), 1);
        tick(1);
        check("short_level_fall", 32'(key_level[1]), 0);
        tick(15);

        // Long + repeat on key[2], 60 cycles: long at +26, repeats every 8,
        // the one due on the release cycle (+66) is suppressed
        c0 = cyc;
        push(4'b0000, 4'b0100, 4'b0000, c0 + 26);
        push(4'b0000, 4'b0000, 4'b0100, c0 + 34);
        push(4'b0000, 4'b0000, 4'b0100, c0 + 42);
        push(4'b0000, 4'b0000, 4'b0100, c0 + 50);
        push(4'b0000, 4'b0000, 4'b0100, c0 + 58);
        key[2] = 1'b0;
        tick(60);
        key[2] = 1'b1;
        tick(30);

        // Boundary: 20 debounced hold cycles -> short only
        c0 = cyc;
        push(4'b0010, 4'b0000, 4'b0000, c0 + 26);
        key[1] = 1'b0;
        tick(20);
        key[1] = 1'b1;
        tick(25);

        // Boundary: 21 debounced hold cycles -> long only
        c0 = cyc;
        push(4'b0000, 4'b0010, 4'b0000, c0 + 26);
        key[1] = 1'b0;
        tick(21);
        key[1] = 1'b1;
        tick(25);

        // Reset while held: key[3] pressed, reset mid-press, held 50 cycles
        c0 = cyc;
        key[3] = 1'b0;
        tick(10);
        check("held_level_before_rst", 32'(key_level[3]), 1);
        rst = 1'b1;
        tick(1);
        check("held_level_after_rst", 32'(key_level), 0);
        check("held_pulses_after_rst", 32'(short_press | long_press | repeat_press), 0);
        rst = 1'b0;
        tick(50);
        check("locked_level_follows", 32'(key_level[3]), 1);
        key[3] = 1'b1;
        tick(20);
        c0 = cyc;
        push(4'b1000, 4'b0000, 4'b0000, c0 + 16);
        key[3] = 1'b0;
        tick(10);
        key[3] = 1'b1;
        tick(20);

        // Concurrency: key[0] and key[3] together, 10 cycles
        c0 = cyc;
        push(4'b1001, 4'b0000, 4'b0000, c0 + 16);
        key = 4'b0110;
        tick(10);
        key = 4'b1111;
        tick(20);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
